program_loader: RTL and testbench

- Boot-time stage that sits upstream of the 16x8 memory and owns its 15-bit input bus until a program is resident.
- Accepts a byte stream over a valid/ready handshake, writes it to consecutive addresses from 0, and keeps a shadow copy.
- Reads every written byte back and compares it with the shadow copy.
- On a clean verify, hands the memory bus to the CPU and asserts cpu_run.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/program_loader_if.sv | 28 ++
 rtl/bus_pack.sv | 26 ++
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Purpose : memory bus field layout, memory ctrl codes and loader states
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_MSB = 14;
  localparam int DATA_LSB = 7;
  localparam int ADDR_MSB = 6;
  localparam int ADDR_LSB = 3;
  localparam int CTRL_MSB = 2;
  localparam int CTRL_LSB = 0;
  localparam int BUS_W    = DATA_MSB + 1;

  localparam logic [2:0] CTRL_NOP   = 3'b000;
  localparam logic [2:0] CTRL_WRITE = 3'b001;
  localparam logic [2:0] CTRL_READ  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_if
// Purpose : byte-stream handshake plus memory / CPU bus seen by the loader
// Rev     : 1.0  initial release
// ============================================================================
interface program_loader_if;
  import cpu_pkg::*;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] cpu_mem_in;
  logic [BUS_W-1:0] mem_in;
  logic [7:0]       mem_out;

  modport master (
    output in_data, in_valid, cpu_mem_in, mem_out,
    input  in_ready, mem_in
  );

  modport slave (
    input  in_data, in_valid, cpu_mem_in, mem_out,
    output in_ready, mem_in
  );

endinterface
`default_nettype wire

// File: rtl/bus_pack.sv
`default_nettype none
// ============================================================================
// Module  : bus_pack
// Purpose : packs {data,addr,ctrl} into the 15-bit memory bus and unpacks it
// Rev     : 1.0  initial release
// ============================================================================
module bus_pack
  import cpu_pkg::*;
(
  input  wire logic [DATA_MSB-DATA_LSB:0] i_data,
  input  wire logic [ADDR_MSB-ADDR_LSB:0] i_addr,
  input  wire logic [CTRL_MSB-CTRL_LSB:0] i_ctrl,
  output logic      [BUS_W-1:0]           o_bus,
  input  wire logic [BUS_W-1:0]           i_bus,
  output logic      [DATA_MSB-DATA_LSB:0] o_data,
  output logic      [ADDR_MSB-ADDR_LSB:0] o_addr,
  output logic      [CTRL_MSB-CTRL_LSB:0] o_ctrl
);

  assign o_bus  = {i_data, i_addr, i_ctrl};
  assign o_data = i_bus[DATA_MSB:DATA_LSB];
  assign o_addr = i_bus[ADDR_MSB:ADDR_LSB];
  assign o_ctrl = i_bus[CTRL_MSB:CTRL_LSB];

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Purpose : loads a byte stream into memory, verifies it, then releases the CPU
// Rev     : 1.0  initial release
// ============================================================================
module program_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1
)
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               start,
  input  wire logic [4:0]         load_len,
  program_loader_if.slave         bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [$clog2(DEPTH)-1:0] err_addr,
  output logic                    cpu_run
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0]            c_depth   = 5'(DEPTH);
  localparam logic [BUS_W-1:0]      c_nop_bus = {8'h00, 4'h0, CTRL_NOP};
  localparam logic [RD_LATENCY-1:0] c_last    = RD_LATENCY'(1) << (RD_LATENCY - 1);

  loader_state_t         r_state;
  logic [4:0]            r_len;
  logic [4:0]            r_wr_cnt;
  logic [4:0]            r_rd_cnt;
  logic [7:0]            r_shadow [DEPTH];
  logic [BUS_W-1:0]      r_mem_in;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [AW-1:0]         r_err_addr;
  logic                  r_cpu_run;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [AW-1:0]         r_pipe_addr [RD_LATENCY];

  logic [4:0]       w_len;
  logic [7:0]       w_cmd_data;
  logic [AW-1:0]    w_cmd_addr;
  logic [2:0]       w_cmd_ctrl;
  logic [BUS_W-1:0] w_cmd_bus;
  logic [7:0]       w_unused_data;
  logic [AW-1:0]    w_cur_addr;
  logic [2:0]       w_cur_ctrl;
  logic             w_issue_rd;
  logic             w_cmp_vld;
  logic [AW-1:0]    w_cmp_addr;
  logic             w_mismatch;
  logic             w_inflight;

  assign w_len = (load_len > c_depth) ? c_depth : load_len;

  always_comb begin
    w_cmd_data = 8'h00;
    w_cmd_addr = r_rd_cnt[AW-1:0];
    w_cmd_ctrl = CTRL_READ;
    if (r_state == ST_LOAD) begin
      w_cmd_data = bus.in_data;
      w_cmd_addr = r_wr_cnt[AW-1:0];
      w_cmd_ctrl = CTRL_WRITE;
    end
  end

  bus_pack u_bus_pack (
    .i_data (w_cmd_data),
    .i_addr (w_cmd_addr),
    .i_ctrl (w_cmd_ctrl),
    .o_bus  (w_cmd_bus),
    .i_bus  (r_mem_in),
    .o_data (w_unused_data),
    .o_addr (w_cur_addr),
    .o_ctrl (w_cur_ctrl)
  );

  // The read currently on the bus feeds the address pipeline; its last stage
  // lines up with the cycle the memory returns that address's data.
  assign w_issue_rd = (w_cur_ctrl == CTRL_READ);
  assign w_cmp_vld  = r_pipe_vld[RD_LATENCY-1];
  assign w_cmp_addr = r_pipe_addr[RD_LATENCY-1];
  assign w_mismatch = (r_state == ST_VERIFY) && w_cmp_vld &&
                      (bus.mem_out != r_shadow[w_cmp_addr]);
  assign w_inflight = w_issue_rd || ((r_pipe_vld & ~c_last) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_mem_in   <= c_nop_bus;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_addr <= '0;
      r_cpu_run  <= 1'b0;
      r_pipe_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_addr[i] <= '0;
    end else begin
      r_mem_in       <= c_nop_bus;
      r_pipe_vld[0]  <= w_issue_rd && (r_state == ST_VERIFY) && !w_mismatch;
      r_pipe_addr[0] <= w_cur_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1] && !w_mismatch;
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end

      case (r_state)
        ST_IDLE, ST_FAIL: begin
          if (start) begin
            r_len      <= w_len;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
            if (w_len == 5'd0) begin
              r_state   <= ST_RUN;
              r_done    <= 1'b1;
              r_cpu_run <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_done     <= 1'b0;
              r_cpu_run  <= 1'b0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (bus.in_valid && r_in_ready) begin
            r_shadow[r_wr_cnt[AW-1:0]] <= bus.in_data;
            r_mem_in                   <= w_cmd_bus;
            r_wr_cnt                   <= r_wr_cnt + 5'd1;
            if (r_wr_cnt + 5'd1 == r_len) r_in_ready <= 1'b0;
          end else if (r_wr_cnt == r_len) begin
            r_state <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_mismatch) begin
            r_state    <= ST_FAIL;
            r_error    <= 1'b1;
            r_err_addr <= w_cmp_addr;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
          end else if (r_rd_cnt != r_len) begin
            r_mem_in <= w_cmd_bus;
            r_rd_cnt <= r_rd_cnt + 5'd1;
          end else if (!w_inflight) begin
            r_state   <= ST_RUN;
            r_done    <= 1'b1;
            r_cpu_run <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_in   = r_cpu_run ? bus.cpu_mem_in : r_mem_in;
  assign bus.in_ready = r_in_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_addr     = r_err_addr;
  assign cpu_run      = r_cpu_run;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader
// Purpose : directed self-checking bench for program_loader with a 16x8 memory
// Rev     : 1.0  initial release
// ============================================================================
module tb_program_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] load_len;
  logic       busy, done, error, cpu_run;
  logic [3:0] err_addr;

  program_loader_if ifc ();

  program_loader #(.DEPTH(16), .RD_LATENCY(1)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_len (load_len),
    .bus      (ifc),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_addr (err_addr),
    .cpu_run  (cpu_run)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle registered read, optional corruption of address 5.
  logic [7:0] mem [16];
  logic [7:0] rd_q;
  logic       corrupt;
  logic       clr_log;
  int         n_wr, n_rd, cyc;
  logic [3:0] wr_addr_log [32];
  logic [7:0] wr_data_log [32];
  int         wr_cyc_log  [32];
  logic [3:0] rd_addr_log [32];

  wire [7:0] m_data = ifc.mem_in[DATA_MSB:DATA_LSB];
  wire [3:0] m_addr = ifc.mem_in[ADDR_MSB:ADDR_LSB];
  wire [2:0] m_ctrl = ifc.mem_in[CTRL_MSB:CTRL_LSB];

  assign ifc.mem_out = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_ctrl == CTRL_WRITE) mem[m_addr] <= m_data;
    if (m_ctrl == CTRL_READ) rd_q <= (corrupt && m_addr == 4'd5) ? 8'hFF : mem[m_addr];
    if (clr_log) begin
      n_wr <= 0;
      n_rd <= 0;
    end else begin
      if (m_ctrl == CTRL_WRITE) begin
        if (n_wr < 32) begin
          wr_addr_log[n_wr] <= m_addr;
          wr_data_log[n_wr] <= m_data;
          wr_cyc_log[n_wr]  <= cyc;
        end
        n_wr <= n_wr + 1;
      end
      if (m_ctrl == CTRL_READ) begin
        if (n_rd < 32) rd_addr_log[n_rd] <= m_addr;
        n_rd <= n_rd + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] len);
    start    = 1'b1;
    load_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Offers bytes (i+off)*8'h11; rnd toggles in_valid pseudo-randomly.
  task automatic send_bytes(input int n, input int off, input bit rnd);
    int i = 0;
    int budget = 400;
    logic [7:0] b;
    while (i < n && budget > 0) begin
      b = 8'(i + off);
      ifc.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ifc.in_data  = 8'(b * 8'h11);
      if (ifc.in_valid && ifc.in_ready) i++;
      @(negedge clk);
      budget--;
    end
    ifc.in_valid = 1'b0;
    if (i < n) check_eq("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_done();
    int budget = 200;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!done) check_eq("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int bad;
    rst_n          = 1'b0;
    start          = 1'b0;
    load_len       = 5'd0;
    corrupt        = 1'b0;
    clr_log        = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_data    = 8'h00;
    ifc.cpu_mem_in = 15'h0000;

    // Reset values
    do_reset();
    check_eq("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check_eq("rst_busy",     32'(busy),         32'd0);
    check_eq("rst_done",     32'(done),         32'd0);
    check_eq("rst_error",    32'(error),        32'd0);
    check_eq("rst_err_addr", 32'(err_addr),     32'd0);
    check_eq("rst_cpu_run",  32'(cpu_run),      32'd0);
    check_eq("rst_mem_in",   32'(ifc.mem_in),   32'h0);

    // Reset in the middle of a load
    start_load(5'd8);
    send_bytes(3, 1, 1'b0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_mem_in",   32'(ifc.mem_in),   32'h0);
    check_eq("mid_in_ready", 32'(ifc.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_busy_after", 32'(busy), 32'd0);

    // Four bytes, in_valid always high
    clear_log();
    start_load(5'd4);
    send_bytes(4, 1, 1'b0);
    wait_done();
    check_eq("t4_nwr", 32'(n_wr), 32'd4);
    check_eq("t4_nrd", 32'(n_rd), 32'd4);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wr_addr_log[i] != 4'(i)) bad++;
      if (wr_data_log[i] != 8'((i + 1) * 8'h11)) bad++;
      if (rd_addr_log[i] != 4'(i)) bad++;
    end
    check_eq("t4_seq",     32'(bad), 32'd0);
    check_eq("t4_w0_addr", 32'(wr_addr_log[0]), 32'd0);
    check_eq("t4_w3_data", 32'(wr_data_log[3]), 32'h44);
    check_eq("t4_consec",  32'(wr_cyc_log[3] - wr_cyc_log[0]), 32'd3);
    check_eq("t4_done",    32'(done),    32'd1);
    check_eq("t4_cpu_run", 32'(cpu_run), 32'd1);
    check_eq("t4_error",   32'(error),   32'd0);
    check_eq("t4_busy",    32'(busy),    32'd0);
    ifc.cpu_mem_in = 15'h1A5A;
    #1;
    check_eq("t4_fwd_a", 32'(ifc.mem_in), 32'h1A5A);
    ifc.cpu_mem_in = 15'h0123;
    #1;
    check_eq("t4_fwd_b", 32'(ifc.mem_in), 32'h0123);
    ifc.cpu_mem_in = 15'h0000;
    @(negedge clk);

    // Sixteen bytes with randomly toggled in_valid
    do_reset();
    clear_log();
    start_load(5'd16);
    send_bytes(16, 0, 1'b1);
    check_eq("t16_in_ready", 32'(ifc.in_ready), 32'd0);
    wait_done();
    check_eq("t16_nwr", 32'(n_wr), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (wr_addr_log[i] != 4'(i)) bad++;
    check_eq("t16_addrs", 32'(bad), 32'd0);
    check_eq("t16_done",  32'(done),    32'd1);
    check_eq("t16_run",   32'(cpu_run), 32'd1);

    // Corrupted read at address 5, then a clean restart from FAIL
    do_reset();
    corrupt = 1'b1;
    start_load(5'd8);
    send_bytes(8, 0, 1'b0);
    wait_done();
    check_eq("bad_w5",       32'(mem[5]),     32'h55);
    check_eq("bad_error",    32'(error),      32'd1);
    check_eq("bad_err_addr", 32'(err_addr),   32'd5);
    check_eq("bad_cpu_run",  32'(cpu_run),    32'd0);
    check_eq("bad_mem_in",   32'(ifc.mem_in), 32'h0);
    check_eq("bad_busy",     32'(busy),       32'd0);
    corrupt = 1'b0;
    start_load(5'd8);
    check_eq("re_done_clr", 32'(done), 32'd0);
    send_bytes(8, 0, 1'b0);
    wait_done();
    check_eq("re_error",   32'(error),   32'd0);
    check_eq("re_cpu_run", 32'(cpu_run), 32'd1);

    // Zero length
    do_reset();
    clear_log();
    start_load(5'd0);
    @(negedge clk);
    check_eq("len0_done", 32'(done),    32'd1);
    check_eq("len0_run",  32'(cpu_run), 32'd1);
    check_eq("len0_nwr",  32'(n_wr),    32'd0);

    // Oversized length is clamped
    do_reset();
    clear_log();
    start_load(5'd20);
    send_bytes(16, 2, 1'b0);
    check_eq("len20_in_ready", 32'(ifc.in_ready), 32'd0);
    wait_done();
    check_eq("len20_nwr",  32'(n_wr),            32'd16);
    check_eq("len20_last", 32'(wr_addr_log[15]), 32'd15);
    check_eq("len20_run",  32'(cpu_run),         32'd1);

    // start and in_valid during VERIFY are ignored
    do_reset();
    clear_log();
    start_load(5'd6);
    send_bytes(6, 3, 1'b0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hEE;
    @(negedge clk);
    check_eq("ver_busy", 32'(busy), 32'd1);
    start_load(5'd3);
    check_eq("ver_in_ready", 32'(ifc.in_ready), 32'd0);
    wait_done();
    ifc.in_valid = 1'b0;
    check_eq("ver_nwr",   32'(n_wr),    32'd6);
    check_eq("ver_nrd",   32'(n_rd),    32'd6);
    check_eq("ver_run",   32'(cpu_run), 32'd1);
    check_eq("ver_error", 32'(error),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
